// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 program-counter logic.
package msrv32_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  localparam int unsigned DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned PC_INCR              = 4;

endpackage

// File: rtl/msrv32_pc_pipe_stage.sv
// One {pc, valid} slot of the PC tracking chain: loads when shifting, and a
// flush kills the valid bit while leaving the slot otherwise untouched.
module msrv32_pc_pipe_stage
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            shift_en_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  // NOTE: flops use non-blocking assignments so every stage samples its
  // neighbour's pre-edge value and the chain shifts by exactly one slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (shift_en_i) begin
      pc_q    <= pc_i;
      valid_q <= valid_i;
    end
  end

  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/msrv32_pc_fetch_reg.sv
// Program-counter register with redirect/stall/flush control, a valid/ready
// fetch handshake, misaligned-target trapping and a PC tracking chain.
module msrv32_pc_fetch_reg
  import msrv32_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned     ALIGN        = 4,
  parameter int unsigned     PIPE_DEPTH   = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [XLEN-1:0] pc_mux_in,
  input  logic            pc_load_in,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            fetch_ready_in,
  output logic            fetch_valid_out,
  output logic [XLEN-1:0] iaddr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic [XLEN-1:0] pc_pipe_out,
  output logic            pc_pipe_valid_out,
  output logic            misaligned_out
);

  localparam int unsigned ALIGN_BITS = $clog2(ALIGN);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus_4;
  logic            fetch_valid_q;
  logic            misaligned_q;
  logic            target_aligned;
  logic            accept;

  assign target_aligned = (pc_mux_in[ALIGN_BITS-1:0] == '0);
  assign pc_plus_4      = pc_q + XLEN'(PC_INCR);
  assign accept         = fetch_valid_q & fetch_ready_in & ~stall_in;

  // NOTE: pc_d is defaulted before any branch so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    pc_d = pc_q;
    if (pc_load_in) begin
      if (target_aligned) pc_d = pc_mux_in;
    end else if (!stall_in && accept) begin
      pc_d = pc_plus_4;
    end
  end

  // A redirect wins over stall and over BOOT; a misaligned one parks in TRAP.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q          <= RESET_VECTOR;
      state_q       <= BOOT;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= pc_load_in & ~target_aligned;
      if (pc_load_in) begin
        if (target_aligned) begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end else begin
          state_q       <= TRAP;
          fetch_valid_q <= 1'b0;
        end
      end else if (state_q == BOOT) begin
        state_q       <= RUN;
        fetch_valid_q <= 1'b1;
      end
    end
  end

  logic [XLEN-1:0] chain_pc    [PIPE_DEPTH+1];
  logic            chain_valid [PIPE_DEPTH+1];

  assign chain_pc[0]    = pc_q;
  assign chain_valid[0] = accept;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_pipe
    msrv32_pc_pipe_stage #(
      .XLEN(XLEN)
    ) u_stage (
      .clk_i      (clk_in),
      .rst_i      (rst_in),
      .shift_en_i (~stall_in),
      .flush_i    (flush_in),
      .pc_i       (chain_pc[k]),
      .valid_i    (chain_valid[k]),
      .pc_o       (chain_pc[k+1]),
      .valid_o    (chain_valid[k+1])
    );
  end

  assign fetch_valid_out   = fetch_valid_q;
  assign iaddr_out         = pc_q;
  assign pc_out            = pc_q;
  assign pc_plus_4_out     = pc_plus_4;
  assign pc_pipe_out       = chain_pc[PIPE_DEPTH];
  assign pc_pipe_valid_out = chain_valid[PIPE_DEPTH];
  assign misaligned_out    = misaligned_q;

endmodule

// File: tb/tb_msrv32_pc_fetch_reg.sv
// Directed and randomized checks of msrv32_pc_fetch_reg against a
// cycle-level behavioural model of the PC, handshake and tracking chain.
module tb_msrv32_pc_fetch_reg;

  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_1000;
  localparam int unsigned ALIGN = 4;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_in = 1'b1;
  logic [XLEN-1:0] pc_mux_in = '0;
  logic            pc_load_in = 1'b0;
  logic            stall_in = 1'b0;
  logic            flush_in = 1'b0;
  logic            fetch_ready_in = 1'b0;
  logic            fetch_valid_out;
  logic [XLEN-1:0] iaddr_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_4_out;
  logic [XLEN-1:0] pc_pipe_out;
  logic            pc_pipe_valid_out;
  logic            misaligned_out;

  always #5 clk = ~clk;

  msrv32_pc_fetch_reg #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .ALIGN(ALIGN), .PIPE_DEPTH(DEPTH)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .pc_mux_in         (pc_mux_in),
    .pc_load_in        (pc_load_in),
    .stall_in          (stall_in),
    .flush_in          (flush_in),
    .fetch_ready_in    (fetch_ready_in),
    .fetch_valid_out   (fetch_valid_out),
    .iaddr_out         (iaddr_out),
    .pc_out            (pc_out),
    .pc_plus_4_out     (pc_plus_4_out),
    .pc_pipe_out       (pc_pipe_out),
    .pc_pipe_valid_out (pc_pipe_valid_out),
    .misaligned_out    (misaligned_out)
  );

  // Reference model: mode 0 = booting, 1 = fetching, 2 = trapped.
  typedef struct {
    logic [31:0] pc;
    bit          v;
  } entry_t;

  entry_t      chain[$];
  int          mode = 0;
  logic [31:0] m_pc = '0;
  bit          m_fv = 1'b0;
  bit          m_mis = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit          acc;
    logic [31:0] old_pc;
    entry_t      e;
    acc    = m_fv && fetch_ready_in && !stall_in;
    old_pc = m_pc;
    if (rst_in) begin
      mode  = 0;
      m_pc  = RV;
      m_fv  = 1'b0;
      m_mis = 1'b0;
      chain.delete();
      repeat (DEPTH) chain.push_back('{pc: 32'h0, v: 1'b0});
      return;
    end
    m_mis = 1'b0;
    if (pc_load_in) begin
      if (pc_mux_in % ALIGN == 0) begin
        m_pc = pc_mux_in;
        mode = 1;
      end else begin
        m_mis = 1'b1;
        mode  = 2;
      end
    end else begin
      if (mode == 0) mode = 1;
      if (acc) m_pc = m_pc + 32'd4;
    end
    if (flush_in) begin
      foreach (chain[i]) chain[i].v = 1'b0;
    end else if (!stall_in) begin
      e.pc = old_pc;
      e.v  = acc;
      chain.push_front(e);
      void'(chain.pop_back());
    end
    m_fv = (mode == 1);
  endtask

  task automatic check_all();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    check("pc_out", pc_out, m_pc);
    check("iaddr_out", iaddr_out, m_pc);
    check("fetch_valid", fetch_valid_out, m_fv);
    check("pc_plus_4", pc_plus_4_out, p4);
    check("misaligned", misaligned_out, m_mis);
    check("pipe_valid", pc_pipe_valid_out, chain[DEPTH-1].v);
    if (chain[DEPTH-1].v) check("pipe_pc", pc_pipe_out, chain[DEPTH-1].pc);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset with ready held high.
    rst_in = 1'b1; fetch_ready_in = 1'b1;
    step(); step();
    check("rst_pc", pc_out, 32'h1000);
    check("rst_fv", fetch_valid_out, 1'b0);
    check("rst_pipe_pc", pc_pipe_out, 32'h0);
    check("rst_pipe_v", pc_pipe_valid_out, 1'b0);

    rst_in = 1'b0;
    step();
    check("first_fv", fetch_valid_out, 1'b1);
    check("first_iaddr", iaddr_out, 32'h1000);
    step();
    check("seq_1004", iaddr_out, 32'h1004);
    step();
    check("seq_1008", iaddr_out, 32'h1008);
    check("chain_1000_v", pc_pipe_valid_out, 1'b1);
    check("chain_1000_pc", pc_pipe_out, 32'h1000);

    // Back-pressure: address must hold, nothing new enters the chain.
    fetch_ready_in = 1'b0;
    repeat (3) begin
      step();
      check("hold_iaddr", iaddr_out, 32'h1008);
      check("hold_fv", fetch_valid_out, 1'b1);
    end
    check("hold_no_entries", pc_pipe_valid_out, 1'b0);
    fetch_ready_in = 1'b1;
    step();
    check("resume_100c", iaddr_out, 32'h100C);

    // Redirect under stall.
    stall_in = 1'b1; pc_load_in = 1'b1; pc_mux_in = 32'h2000;
    step();
    check("stall_redirect", pc_out, 32'h2000);
    stall_in = 1'b0;

    // Misaligned redirect, trap, repeat pulse, recovery.
    pc_mux_in = 32'h2002;
    step();
    check("mis_pulse", misaligned_out, 1'b1);
    check("mis_fv", fetch_valid_out, 1'b0);
    check("mis_pc", pc_out, 32'h2000);
    pc_load_in = 1'b0;
    step();
    check("mis_one_cycle", misaligned_out, 1'b0);
    check("trap_fv", fetch_valid_out, 1'b0);
    pc_load_in = 1'b1; pc_mux_in = 32'h2001;
    step();
    check("trap_repulse", misaligned_out, 1'b1);
    pc_mux_in = 32'h3000;
    step();
    check("recover_pc", iaddr_out, 32'h3000);
    check("recover_fv", fetch_valid_out, 1'b1);
    pc_load_in = 1'b0;

    // Flush after two accepts.
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step(); step(); step();
    check("flush_pre_v", pc_pipe_valid_out, 1'b1);
    check("flush_pre_pc", pc_pipe_out, 32'h1000);
    flush_in = 1'b1;
    step();
    check("flush_v", pc_pipe_valid_out, 1'b0);
    check("flush_pc_moves", pc_out, 32'h100C);
    flush_in = 1'b0; fetch_ready_in = 1'b0;
    step();
    check("flush_dropped", pc_pipe_valid_out, 1'b0);
    step();
    check("flush_empty", pc_pipe_valid_out, 1'b0);

    // Wrap at the top of the address space.
    fetch_ready_in = 1'b1; pc_load_in = 1'b1; pc_mux_in = 32'hFFFF_FFFC;
    step();
    pc_load_in = 1'b0;
    step();
    check("wrap_pc", pc_out, 32'h0);
    check("wrap_plus4", pc_plus_4_out, 32'h4);
    check("wrap_no_trap", misaligned_out, 1'b0);

    // Randomized traffic.
    repeat (500) begin
      rst_in         = ($urandom % 60) == 0;
      pc_load_in     = ($urandom % 8) == 0;
      pc_mux_in      = $urandom;
      if (($urandom % 4) != 0) pc_mux_in[1:0] = 2'b00;
      stall_in       = ($urandom % 5) == 0;
      flush_in       = ($urandom % 10) == 0;
      fetch_ready_in = ($urandom % 3) != 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_pc_fetch_reg.md
# msrv32_pc_fetch_reg

Parametrised program-counter register for the msrv32 core. It replaces the bare PC flop with a block that has:
- a configurable reset vector;
- redirect, stall and flush control;
- a valid/ready fetch handshake;
- a misaligned-target trap;
- a PIPE_DEPTH-deep PC/valid shift chain feeding downstream stages.

It sits between the PC mux and the instruction-fetch interface.

## Interface
- XLEN, 32, PC width in bits (32 or 64)
- RESET_VECTOR, 0, PC value loaded on reset, XLEN bits, must be ALIGN-aligned
- ALIGN, 4, required target alignment in bytes (2 or 4)
- PIPE_DEPTH, 2, stages in the PC tracking chain (1..4)
- clk_in  input  1  single clock, rising edge
- rst_in  input  1  synchronous, active-high reset
- pc_mux_in  input  XLEN  redirect target
- pc_load_in  input  1  redirect strobe: take pc_mux_in
- stall_in  input  1  freeze PC advance and pipe chain
- flush_in  input  1  invalidate all pipe chain entries
- fetch_ready_in  input  1  fetch unit accepts iaddr_out
- fetch_valid_out  output  1  iaddr_out is a valid request
- iaddr_out  output  XLEN  fetch address, equal to pc_out
- pc_out  output  XLEN  current PC, registered
- pc_plus_4_out  output  XLEN  pc_out + 4 modulo 2^XLEN, combinational
- pc_pipe_out  output  XLEN  PC at the last chain stage
- pc_pipe_valid_out  output  1  valid bit at the last chain stage
- misaligned_out  output  1  one-cycle pulse on a misaligned redirect

## Operation
- States:
  - BOOT: fetch_valid_out=0. Goes to RUN on the next clock.
  - RUN: fetch_valid_out=1.
  - TRAP: fetch_valid_out=0. Waiting for an aligned redirect.
- Reset (rst_in=1 at posedge), regardless of other inputs:
  - pc_out=RESET_VECTOR;
  - state=BOOT, fetch_valid_out=0;
  - all chain valids=0 and chain PCs=0;
  - misaligned_out=0.
- PC update priority, per clock: rst_in > pc_load_in > stall_in > accept > hold.
  - accept = fetch_valid_out & fetch_ready_in & !stall_in.
- Accept: pc_out <= pc_out + 4, wrapping modulo 2^XLEN with no flag. Example: 0xFFFF_FFFC becomes 0x0000_0000.
- Redirect with an aligned target, in any state:
  - pc_out <= pc_mux_in;
  - state <= RUN.
  - A pending unaccepted request is abandoned and is not entered into the chain.
  - A redirect overrides stall_in.
- Redirect with a misaligned target (pc_mux_in mod ALIGN ≠ 0):
  - pc_out is unchanged;
  - misaligned_out=1 for one cycle;
  - state <= TRAP.
- TRAP: leaves only on reset or on an aligned redirect. A misaligned redirect in TRAP pulses misaligned_out again.
- Handshake rule: while fetch_valid_out=1 and fetch_ready_in=0, iaddr_out holds stable. Only a redirect or reset may change it.
- Chain shifts when !stall_in:
  - stage0 <= {iaddr_out, accept};
  - stage k <= stage k-1.
- Chain holds when stall_in=1.
- flush_in clears every chain valid on that clock and overrides the shift. The entry that would have entered stage0 is also dropped. PC is unaffected.
- flush_in together with pc_load_in: both take effect.

## Timing
- pc_out and fetch_valid_out are registered.
- The first fetch request is valid 2 cycles after the rst_in falling clock edge (BOOT, then RUN).
- Redirect-to-fetch latency: 1 clock. The new iaddr_out is visible the cycle after pc_load_in.
- Chain latency: PIPE_DEPTH unstalled clocks from accept to pc_pipe_valid_out.
- misaligned_out asserts in the cycle after the offending pc_load_in and lasts exactly 1 cycle.
- Reset asserted mid-stall or mid-TRAP: reset behaviour applies on that edge.

## Structure
- msrv32_pkg holds:
  - the state enum {BOOT, RUN, TRAP};
  - the default XLEN;
  - the default RESET_VECTOR;
  - the PC increment constant (4).
- One sub-module, msrv32_pc_pipe_stage: a single {pc, valid} register with shift-enable and flush. It is instantiated PIPE_DEPTH times by a generate loop.
- Alignment check and next-PC mux stay in the top module.

## Test plan
- Reset with RESET_VECTOR=0x0000_1000, fetch_ready_in=1 held -> iaddr_out sequence 0x1000, 0x1004, 0x1008. fetch_valid_out first high 2 cycles after reset release.
- fetch_ready_in=0 for 3 cycles at PC 0x1008 -> iaddr_out stays 0x1008 and fetch_valid_out stays 1. No chain entries are added. Resumes at 0x100C after ready.
- pc_load_in with target 0x2000 during stall_in=1 -> pc_out=0x2000 next cycle. The stall does not block the redirect.
- Misaligned redirect to 0x2002 with ALIGN=4 -> misaligned_out pulses once, fetch_valid_out=0, pc_out unchanged. A following redirect to 0x3000 resumes fetch at 0x3000.
- PIPE_DEPTH=2 with accepts at 0x1000 and 0x1004, then flush_in -> pc_pipe_valid_out shows 0x1000 valid 2 clocks after its accept, then 0 on all stages after the flush.
- PC 0xFFFF_FFFC accepted -> next pc_out=0x0000_0000 and pc_plus_4_out=0x0000_0004, no trap.
